// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    // A request may only be issued when the slot is free or is being drained.
    function automatic logic slot_ok(input logic if_valid, input logic id_ready);
        return (!if_valid) || id_ready;
    endfunction

endpackage

// File: rtl/ifetch_slot.sv
// Single-entry output register between fetch and decode: load, consume, flush.
module ifetch_slot
    import ifetch_unit_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic [ILEN-1:0] i_load_instr,
    input  logic            i_consume,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [ILEN-1:0] o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_instr;

    // Flush beats load beats consume; payload is kept when the slot is emptied.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_pc    <= {XLEN{1'b0}};
            r_instr <= {ILEN{1'b0}};
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_load_pc;
            r_instr <= i_load_instr;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: single-outstanding imem requests, response buffering,
// PC stall generation and redirect-driven discard of in-flight fetches.
module ifetch_unit
    import ifetch_unit_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_jump_flag,
    output logic            o_stall,
    output logic            o_imem_req_valid,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_req_ready,
    input  logic            i_imem_resp_valid,
    input  logic [ILEN-1:0] i_imem_resp_data,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [ILEN-1:0] o_if_instr,
    input  logic            i_id_ready
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_req_pc;
    logic            w_req_valid;
    logic            w_accept;
    logic            w_load;
    logic            w_consume;

    // Held low during reset so the memory never sees a request while it resets.
    assign w_req_valid = (!i_reset) && (r_state == ST_REQ)
                       && slot_ok(o_if_valid, i_id_ready) && (!i_jump_flag);
    assign w_accept    = w_req_valid && i_imem_req_ready;
    assign w_consume   = o_if_valid && i_id_ready;

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_req_addr  = i_pc;
    assign o_stall          = !w_accept;

    // State register and address of the outstanding request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_REQ;
            r_req_pc <= {XLEN{1'b0}};
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_req_pc <= i_pc;
            end else begin
                r_req_pc <= r_req_pc;
            end
        end
    end

    // Next-state and slot-load decode.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (w_accept) begin
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_imem_resp_valid) begin
                    w_load       = !i_jump_flag;
                    w_state_next = ST_REQ;
                end else if (i_jump_flag) begin
                    w_state_next = ST_DROP;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (i_imem_resp_valid) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_DROP;
                end
            end
            default: begin
                w_state_next = ST_REQ;
            end
        endcase
    end

    ifetch_slot u_slot (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (w_load),
        .i_load_pc    (r_req_pc),
        .i_load_instr (i_imem_resp_data),
        .i_consume    (w_consume),
        .i_flush      (i_jump_flag),
        .o_valid      (o_if_valid),
        .o_pc         (o_if_pc),
        .o_instr      (o_if_instr)
    );

endmodule
